// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared Wishbone widths and arbiter state encoding
package wb_arb_pkg;
    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ERR = 2'd2} arb_state_e;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first requester after last_ptr
module rr_picker #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_ptr,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int W = $clog2(N);
    logic [W-1:0] idx;
    // scan farthest-first so the nearest requester after last_ptr wins
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int i = N; i >= 1; i--) begin
            idx = W'((int'(last_ptr) + i) % N);
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end
endmodule

// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: round-robin Wishbone arbiter in front of the RAM slave (WB_ARB_TIMEOUT_EN adds stall timeout)
module wb_ram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                                 clk,
    input  logic                                 rstn_i,
    input  logic [NUM_MASTERS-1:0]               m_cyc_i,
    input  logic [NUM_MASTERS-1:0]               m_stb_i,
    input  logic [NUM_MASTERS-1:0]               m_we_i,
    input  logic [NUM_MASTERS-1:0][WB_SEL_W-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0][WB_ADR_W-1:0] m_adr_i,
    input  logic [NUM_MASTERS-1:0][WB_DAT_W-1:0] m_dat_i,
    output logic [WB_DAT_W-1:0]                  m_dat_o,
    output logic [NUM_MASTERS-1:0]               m_ack_o,
    output logic [NUM_MASTERS-1:0]               m_err_o,
    output logic                                 s_cyc_o,
    output logic                                 s_stb_o,
    output logic                                 s_we_o,
    output logic [WB_SEL_W-1:0]                  s_sel_o,
    output logic [WB_ADR_W-1:0]                  s_adr_o,
    output logic [WB_DAT_W-1:0]                  s_dat_o,
    input  logic [WB_DAT_W-1:0]                  s_dat_i,
    input  logic                                 s_ack_i,
    input  logic                                 s_err_i
);
    localparam int IW = $clog2(NUM_MASTERS);
    arb_state_e state;
    logic [IW-1:0] owner, last_ptr, gnt_idx;
    logic gnt_valid, busy, own_cyc, own_stb, err_pulse;

    assign busy    = state == BUSY;
    assign own_cyc = m_cyc_i[owner];
    assign own_stb = m_stb_i[owner];

    rr_picker #(.N(NUM_MASTERS)) u_pick (
        .req      (m_cyc_i),
        .last_ptr (last_ptr),
        .gnt_valid(gnt_valid),
        .gnt_idx  (gnt_idx)
    );

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic stall, timeout, err_done;
    assign stall     = busy && own_stb && !s_ack_i && !s_err_i;
    assign timeout   = stall && cnt == CW'(TIMEOUT - 1);
    assign err_pulse = state == ERR && !err_done;
    // count consecutive stalled strobe cycles; the forced err fires only once per ERR visit
    always_ff @(posedge clk or negedge rstn_i)
        if (!rstn_i) begin
            cnt      <= '0;
            err_done <= 1'b0;
        end else begin
            cnt      <= stall ? cnt + 1'b1 : '0;
            err_done <= state == ERR;
        end
`else
    assign err_pulse = 1'b0;
`endif

    // grant on a pending request from IDLE, release when the owner drops cyc
    always_ff @(posedge clk or negedge rstn_i)
        if (!rstn_i) begin
            state    <= IDLE;
            owner    <= '0;
            last_ptr <= IW'(NUM_MASTERS - 1);
        end else if (state == IDLE) begin
            if (gnt_valid) begin
                state <= BUSY;
                owner <= gnt_idx;
            end
        end else if (!own_cyc) begin
            state    <= IDLE;
            last_ptr <= owner;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (timeout) state <= ERR;
`endif

    assign s_cyc_o = busy & own_cyc;
    assign s_stb_o = busy & own_cyc & own_stb;
    assign s_we_o  = busy & m_we_i[owner];
    assign s_sel_o = busy ? m_sel_i[owner] : '0;
    assign s_adr_o = busy ? m_adr_i[owner] : '0;
    assign s_dat_o = busy ? m_dat_i[owner] : '0;
    assign m_dat_o = s_dat_i;
    assign m_ack_o = NUM_MASTERS'(busy & s_ack_i) << owner;
    assign m_err_o = NUM_MASTERS'((busy & s_err_i) | err_pulse) << owner;
endmodule

// File: tb/tb_wb_ram_arbiter.sv
// tb_wb_ram_arbiter: directed scoreboard bench for the two-master RAM arbiter
module tb_wb_ram_arbiter;
    logic clk = 1'b0, rstn = 1'b0;
    logic [1:0] m_cyc = '0, m_stb = '0, m_we = '0;
    logic [1:0][3:0] m_sel = '0;
    logic [1:0][31:0] m_adr = '0, m_dat = '0;
    logic [31:0] m_dat_o, s_adr_o, s_dat_o, s_dat_i;
    logic [1:0] m_ack_o, m_err_o;
    logic s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, stall;
    logic [3:0] s_sel_o;
    logic [31:0] mem [0:63];
    int tests = 0, fails = 0;
    typedef struct {int m; logic we; logic [31:0] d;} sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    wb_ram_arbiter #(.NUM_MASTERS(2), .TIMEOUT(8)) dut (
        .clk(clk), .rstn_i(rstn),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i)
    );

    // RAM slave model: registered single-beat ack, byte-lane writes
    assign s_err_i = 1'b0;
    always @(posedge clk or negedge rstn)
        if (!rstn) begin
            s_ack_i <= 1'b0;
            s_dat_i <= '0;
        end else begin
            s_ack_i <= 1'b0;
            if (s_cyc_o && s_stb_o && !s_ack_i && !stall) begin
                s_ack_i <= 1'b1;
                if (s_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (s_sel_o[b]) mem[s_adr_o[7:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
                end else s_dat_i <= mem[s_adr_o[7:2]];
            end
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_rst();
        m_cyc = '0;
        m_stb = '0;
        rstn  = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic beat(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] expd);
        sb_t e;
        bit got = 0;
        m_stb[m] = 1'b1;
        m_we[m]  = we;
        m_adr[m] = adr;
        m_dat[m] = dat;
        m_sel[m] = sel;
        sb.push_back('{m, we, expd});
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (m_ack_o != 2'b00) begin
                got = 1;
                e = sb.pop_front();
                chk("ack_vec", {30'd0, m_ack_o}, 32'(2'b01 << e.m));
                if (!e.we) chk("rdata", m_dat_o, e.d);
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $error("FAIL ack_timeout: master %0d observed no ack expected ack", m);
            void'(sb.pop_front());
        end
        m_stb[m] = 1'b0;
    endtask

    initial begin
        stall = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cyc", {31'd0, s_cyc_o}, 32'd0);
        chk("rst_adr", s_adr_o, 32'd0);
        chk("rst_ack", {30'd0, m_ack_o}, 32'd0);
        chk("rst_err", {30'd0, m_err_o}, 32'd0);
        rstn = 1'b1;
        // single master write/read plus sub-word byte-lane write
        m_cyc[0] = 1'b1;
        #1 chk("t1_pre", {31'd0, s_cyc_o}, 32'd0);
        @(negedge clk);
        chk("t1_lat", {31'd0, s_cyc_o}, 32'd1);
        beat(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0);
        beat(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF);
        beat(0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0);
        beat(0, 1, 32'h20, 32'h0000AB00, 4'b0010, 32'h0);
        beat(0, 0, 32'h20, 32'h0, 4'hF, 32'h1122AB44);
        m_cyc[0] = 1'b0;
        // simultaneous requests from reset
        do_rst();
        m_adr[0] = 32'h100;
        m_adr[1] = 32'h200;
        m_cyc = 2'b11;
        @(negedge clk);
        chk("t2_first", s_adr_o, 32'h100);
        beat(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF);
        m_cyc[0] = 1'b0;
        @(negedge clk);
        chk("t2_idle", {31'd0, s_cyc_o}, 32'd0);
        @(negedge clk);
        chk("t2_second", s_adr_o, 32'h200);
        beat(1, 0, 32'h20, 32'h0, 4'hF, 32'h1122AB44);
        m_cyc[1] = 1'b0;
        @(negedge clk);
        m_adr[0] = 32'h300;
        m_adr[1] = 32'h400;
        m_cyc = 2'b11;
        @(negedge clk);
        chk("t2_third", s_adr_o, 32'h300);
        m_cyc[0] = 1'b0;
        // master 1 burst while master 0 waits
        @(negedge clk);
        m_adr[1] = 32'h500;
        @(negedge clk);
        chk("t3_grant1", s_adr_o, 32'h500);
        m_adr[0] = 32'h600;
        m_cyc[0] = 1'b1;
        beat(1, 1, 32'h30, 32'hA0A0A0A0, 4'hF, 32'h0);
        beat(1, 1, 32'h34, 32'hB1B1B1B1, 4'hF, 32'h0);
        beat(1, 1, 32'h38, 32'hC2C2C2C2, 4'hF, 32'h0);
        chk("t3_hold", s_adr_o, 32'h38);
        m_cyc[1] = 1'b0;
        @(negedge clk);
        chk("t3_idle", {31'd0, s_cyc_o}, 32'd0);
        @(negedge clk);
        chk("t3_m0", s_adr_o, 32'h600);
        beat(0, 0, 32'h34, 32'h0, 4'hF, 32'hB1B1B1B1);
        m_cyc[0] = 1'b0;
        // asynchronous reset in the middle of a master 1 transfer
        @(negedge clk);
        m_adr[1] = 32'h700;
        m_cyc[1] = 1'b1;
        @(negedge clk);
        chk("t4_m1", s_adr_o, 32'h700);
        m_adr[0] = 32'h800;
        m_dat[1] = 32'h55AA55AA;
        m_cyc[0] = 1'b1;
        m_stb[1] = 1'b1;
        #2 rstn = 1'b0;
        #1;
        chk("t4_cyc", {31'd0, s_cyc_o}, 32'd0);
        chk("t4_stb", {31'd0, s_stb_o}, 32'd0);
        chk("t4_adr", s_adr_o, 32'd0);
        chk("t4_dat", s_dat_o, 32'd0);
        chk("t4_ack", {30'd0, m_ack_o}, 32'd0);
        chk("t4_err", {30'd0, m_err_o}, 32'd0);
        m_stb[1] = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("t4_prio", s_adr_o, 32'h800);
        m_cyc = 2'b00;
        repeat (2) @(negedge clk);
        // stalled slave
        stall = 1'b1;
        m_adr[0] = 32'h40;
        m_we[0] = 1'b0;
        m_cyc[0] = 1'b1;
        @(negedge clk);
        m_stb[0] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
`ifdef WB_ARB_TIMEOUT_EN
            chk($sformatf("t5_err%0d", i), {30'd0, m_err_o}, (i == 8) ? 32'd1 : 32'd0);
            chk($sformatf("t5_cyc%0d", i), {31'd0, s_cyc_o}, (i < 8) ? 32'd1 : 32'd0);
`else
            chk($sformatf("t5_err%0d", i), {30'd0, m_err_o}, 32'd0);
            chk($sformatf("t5_cyc%0d", i), {31'd0, s_cyc_o}, 32'd1);
`endif
        end
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        stall = 1'b0;
        repeat (2) @(negedge clk);
        m_cyc[1] = 1'b1;
        @(negedge clk);
        beat(1, 0, 32'h38, 32'h0, 4'hF, 32'hC2C2C2C2);
        m_cyc[1] = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
